data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Backing main memory on the data side of the CPU pipeline; it sits directly downstream of the data cache.
- Serves 128-bit (16-byte) block reads and writes over the cache's memory interface: READ/WRITE, 28-bit block address, 128-bit data, BUSYWAIT.
- Models a fixed multi-cycle access latency with a small FSM and counter. Storage is a block-addressed register array.

Parameters:
- LATENCY, 5, number of cycles BUSYWAIT stays high per access; legal range 1..255.
- DEPTH_BITS, 8, log2 of the number of 128-bit blocks stored (default 256 blocks = 4 KiB).

Ports:
- CLK  input  1  clock, all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  block read request from the data cache (level).
- WRITE  input  1  block write request from the data cache (level).
- ADDRESS  input  28  block address; only ADDRESS[DEPTH_BITS-1:0] is used, upper bits are ignored (aliasing).
- WRITEDATA  input  128  block to write; byte 0 is [7:0].
- READDATA  output  128  block returned by the last completed read.
- BUSYWAIT  output  1  high while an access is in progress.

Behaviour:
- Reset is synchronous: on a rising edge with RESET=1, state=IDLE, BUSYWAIT=0, READDATA=0, counter=0, and any latched request is discarded (a pending write is never performed). Array contents are not cleared by reset.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - READ|WRITE sampled high at an edge: latch ADDRESS, WRITEDATA and the op, load counter=LATENCY-1, set BUSYWAIT=1 (registered), go to BUSY.
  - READ=WRITE=0: stay in IDLE, BUSYWAIT=0.
- READ and WRITE both high at the sampling edge: WRITE has priority; the op is treated as a write and no read is performed.
- BUSY:
  - counter>0: decrement each edge. Input changes (ADDRESS, WRITEDATA, READ, WRITE deassert) are ignored.
  - counter==0 at an edge: perform the access using the latched values. A write updates array[addr]; a read loads READDATA=array[addr]. Set BUSYWAIT=0 and go to DONE.
- Latency: request sampled at edge k means BUSYWAIT=1 from edge k to edge k+LATENCY, i.e. exactly LATENCY cycles. READDATA is valid from edge k+LATENCY.
- LATENCY=1: counter loads 0, so the access completes on the very next edge.
- DONE: a one-cycle cooldown. Requests are ignored so the cache can drop READ/WRITE after seeing BUSYWAIT fall. Next state is unconditionally IDLE. A request still held in IDLE afterwards starts a new access.
- READDATA holds its value until the next completed read. Writes and reset-free idling do not change it.
- Read-after-write to the same block, issued as separate accesses, returns the newly written data.
- Counter width is 8 bits, so no wrap-around is possible within the legal LATENCY range.
- RESET asserted during BUSY: the access is aborted and the array is left unmodified.
- Reads of never-written blocks return the simulator's initial contents. The bench must write before it reads.

Test Plan:
- Write then read:
  - Write ADDRESS=0x0000010, WRITEDATA=0x00112233_44556677_8899AABB_CCDDEEFF -> BUSYWAIT high exactly 5 cycles, returns to IDLE.
  - Then read the same address -> after 5 busy cycles, READDATA=0x00112233_44556677_8899AABB_CCDDEEFF.
- Latency/handshake timing:
  - READ raised at edge 10 -> BUSYWAIT=1 over edges 10..15, falls at edge 15, READDATA valid at edge 15.
  - READ held high through edge 16 (DONE) -> no restart; a hold into edge 17 starts a new access.
- Input change mid-access: write to 0x05 with data A, then change ADDRESS to 0x06 and data to B at busy cycle 2 -> block 0x05=A, block 0x06 unchanged (read back to confirm).
- Simultaneous READ+WRITE: both high to 0x07 with data 0xDEADBEEF (zero-extended) -> write performed, READDATA unchanged from its prior value; a subsequent read of 0x07 returns 0x...DEADBEEF.
- Reset mid-operation: write 0x09 with data C, RESET at busy cycle 3 -> BUSYWAIT=0 and READDATA=0 on the next edge; a later read of 0x09 returns the previously written value, not C.
- Aliasing and parameters: write 0x100 with DEPTH_BITS=8 -> a read of 0x000 returns the same block. With LATENCY=1, BUSYWAIT is high for exactly one cycle.

Source files
------------

// File: rtl/data_memory.sv
// Block-addressed backing memory behind the data cache. Each access holds
// BUSYWAIT high for LATENCY cycles, then spends one cooldown cycle in DONE.
module data_memory #(
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned DEPTH_BITS = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [27:0]  ADDRESS,
  input  logic [127:0] WRITEDATA,
  output logic [127:0] READDATA,
  output logic         BUSYWAIT
);

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DEPTH  = 1 << DEPTH_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DEPTH_BITS-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    is_write_q, is_write_d;
  logic                    busy_q, busy_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    mem_we_c;
  logic                    unused_addr_c;

  logic [DATA_W-1:0]       mem_q [DEPTH];

  // Upper address bits alias onto the stored blocks.
  assign unused_addr_c = ^ADDRESS[ADDR_W-1:DEPTH_BITS];

  // Next-state, request latch and access sequencing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    busy_d     = busy_q;
    rdata_d    = rdata_q;
    mem_we_c   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (READ || WRITE) begin
          addr_d     = ADDRESS[DEPTH_BITS-1:0];
          wdata_d    = WRITEDATA;
          is_write_d = WRITE;
          cnt_d      = CNT_W'(LATENCY - 1);
          busy_d     = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // An edge that also sees RESET aborts the access without touching the array.
          if (is_write_q) begin
            mem_we_c = !RESET;
          end else begin
            rdata_d = mem_q[addr_q];
          end
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      busy_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      busy_q     <= busy_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign READDATA = rdata_q;
  assign BUSYWAIT = busy_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed and randomized block accesses
// checked against an associative-array model, plus a LATENCY=1 instance.
module tb_data_memory;

  localparam int unsigned LAT  = 5;
  localparam int unsigned DB   = 8;
  localparam int unsigned DB1  = 4;

  typedef struct {
    logic [127:0] rdata;
    int           cycles;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, rd, wr;
  logic [27:0]  addr;
  logic [127:0] wdata, rdata;
  logic         busy;

  logic         rst1, rd1, wr1;
  logic [27:0]  addr1;
  logic [127:0] wdata1, rdata1;
  logic         busy1;

  exp_t         exp_q[$];
  logic [127:0] ref_mem [int];
  logic [127:0] model_rd;
  int           checks = 0;
  int           errors = 0;
  int           busy_cnt = 0;

  always #5 clk = ~clk;

  data_memory #(.LATENCY(LAT), .DEPTH_BITS(DB)) u_dut (
    .CLK(clk), .RESET(rst), .READ(rd), .WRITE(wr), .ADDRESS(addr),
    .WRITEDATA(wdata), .READDATA(rdata), .BUSYWAIT(busy)
  );

  data_memory #(.LATENCY(1), .DEPTH_BITS(DB1)) u_dut1 (
    .CLK(clk), .RESET(rst1), .READ(rd1), .WRITE(wr1), .ADDRESS(addr1),
    .WRITEDATA(wdata1), .READDATA(rdata1), .BUSYWAIT(busy1)
  );

  // Monitor: every falling BUSYWAIT retires one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      busy_cnt++;
    end else if (busy_cnt > 0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion busy_cycles=%0d", busy_cnt);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (busy_cnt != e.cycles) begin
          errors++;
          $display("FAIL busy_cycles got=%0d exp=%0d", busy_cnt, e.cycles);
        end
        checks++;
        if (rdata !== e.rdata) begin
          errors++;
          $display("FAIL readdata got=%h exp=%h", rdata, e.rdata);
        end
      end
      busy_cnt = 0;
    end
  end

  task automatic access(input logic r, input logic w, input logic [27:0] a,
                        input logic [127:0] d, input int change_at,
                        input logic [27:0] new_a, input logic [127:0] new_d,
                        input int reset_at, input bit drop_early, input bit hold);
    exp_t e;
    int   idx;
    bit   done;
    bit   hold_left;
    idx = int'(a[DB-1:0]);
    if (reset_at > 0) begin
      model_rd = '0;
      e.rdata  = '0;
      e.cycles = reset_at;
    end else if (w) begin
      ref_mem[idx] = d;
      e.rdata  = model_rd;
      e.cycles = LAT;
    end else begin
      model_rd = ref_mem[idx];
      e.rdata  = model_rd;
      e.cycles = LAT;
    end
    exp_q.push_back(e);
    if (hold) exp_q.push_back(e);
    hold_left = hold;
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    done = 1'b0;
    for (int i = 1; i <= 600 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        if (hold_left) begin
          hold_left = 1'b0;
          @(negedge clk);
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_no_restart got=%b exp=0", busy);
          end
          @(negedge clk);
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL idle_restart got=%b exp=1", busy);
          end
        end else begin
          rd = 1'b0; wr = 1'b0; rst = 1'b0;
          done = 1'b1;
        end
      end else begin
        if (i == change_at) begin
          addr = new_a; wdata = new_d;
        end
        if (drop_early && i == 1) begin
          rd = 1'b0; wr = 1'b0;
        end
        if (i == reset_at) rst = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout addr=%h", a);
      rd = 1'b0; wr = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic wr_blk(input logic [27:0] a, input logic [127:0] d);
    access(1'b0, 1'b1, a, d, 0, '0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic rd_blk(input logic [27:0] a);
    access(1'b1, 1'b0, a, '0, 0, '0, '0, 0, 1'b0, 1'b0);
  endtask

  task automatic lat1_access(input logic r, input logic w, input logic [27:0] a,
                             input logic [127:0] d, input logic [127:0] exp_rd);
    int n;
    bit fell;
    @(negedge clk);
    rd1 = r; wr1 = w; addr1 = a; wdata1 = d;
    n = 0;
    fell = 1'b0;
    for (int i = 0; i < 50 && !fell; i++) begin
      @(negedge clk);
      if (busy1 === 1'b1) n++;
      else if (n > 0) fell = 1'b1;
    end
    rd1 = 1'b0; wr1 = 1'b0;
    checks++;
    if (!fell || n != 1) begin
      errors++;
      $display("FAIL lat1_busy_cycles got=%0d exp=1", n);
    end
    checks++;
    if (rdata1 !== exp_rd) begin
      errors++;
      $display("FAIL lat1_readdata got=%h exp=%h", rdata1, exp_rd);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    logic [127:0] x, da, db, d6, p, c, q, v, rd_any;
    logic [27:0]  ra;
    int           k, ridx;
    bit           r, w;

    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    model_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (rdata !== '0) begin errors++; $display("FAIL reset_readdata got=%h exp=0", rdata); end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
    rst = 1'b0; rst1 = 1'b0;

    // LATENCY=1 instance with DEPTH_BITS=4 aliasing.
    v = {$urandom, $urandom, $urandom, $urandom};
    lat1_access(1'b0, 1'b1, 28'h13, v, '0);
    lat1_access(1'b1, 1'b0, 28'h03, '0, v);
    lat1_access(1'b1, 1'b0, 28'h13, '0, v);

    x = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    wr_blk(28'h0000010, x);
    rd_blk(28'h0000010);
    access(1'b1, 1'b0, 28'h0000010, '0, 0, '0, '0, 0, 1'b0, 1'b1);

    d6 = {$urandom, $urandom, $urandom, $urandom};
    da = {$urandom, $urandom, $urandom, $urandom};
    db = {$urandom, $urandom, $urandom, $urandom};
    wr_blk(28'h06, d6);
    access(1'b0, 1'b1, 28'h05, da, 2, 28'h06, db, 0, 1'b0, 1'b0);
    rd_blk(28'h05);
    rd_blk(28'h06);

    access(1'b1, 1'b1, 28'h07, 128'hDEADBEEF, 0, '0, '0, 0, 1'b0, 1'b0);
    rd_blk(28'h07);

    p = {$urandom, $urandom, $urandom, $urandom};
    c = ~p;
    wr_blk(28'h09, p);
    access(1'b0, 1'b1, 28'h09, c, 0, '0, '0, 3, 1'b0, 1'b0);
    rd_blk(28'h09);

    q = {$urandom, $urandom, $urandom, $urandom};
    wr_blk(28'h100, q);
    rd_blk(28'h000);

    for (int n = 0; n < 60; n++) begin
      ra   = {28'($urandom) & 28'hFFFFF00} | 28'($urandom_range(32'h20, 32'h2F));
      ridx = int'(ra[DB-1:0]);
      k    = $urandom_range(0, 2);
      r    = (k != 1);
      w    = (k != 0) || !ref_mem.exists(ridx);
      if (w && k == 0) r = 1'b0;
      rd_any = {$urandom, $urandom, $urandom, $urandom};
      access(r, w, ra, rd_any, $urandom_range(0, 4), 28'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, 0,
             1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
